// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - fully associative branch target buffer with saturating direction counters
// Combinational lookup for fetch; table update, flush and misprediction counting from execute.
module branch_target_buffer #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 4,
  parameter int CTR_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [XLEN-1:0]              lk_pc,
  output logic                         lk_hit,
  output logic                         lk_taken,
  output logic [XLEN-1:0]              pred_pc,
  input  logic                         upd_valid,
  input  logic [XLEN-1:0]              upd_pc,
  input  logic [XLEN-1:0]              upd_target,
  input  logic                         upd_taken,
  input  logic                         upd_pred_taken,
  input  logic                         flush,
  output logic [31:0]                  mispred_cnt,
  output logic [$clog2(ENTRIES):0]     valid_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic [ENTRIES-1:0] valid_q;
  logic [XLEN-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [IDX_W-1:0]   ptr_q;

  logic               lk_found;
  logic [IDX_W-1:0]   lk_idx;
  logic               upd_found;
  logic [IDX_W-1:0]   upd_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               alloc;
  logic [IDX_W-1:0]   victim;
  logic [ENTRIES-1:0] valid_d;
  logic [CNT_W-1:0]   cnt_d;

  // Scan high to low so the lowest matching index is the one that sticks.
  always_comb begin
    lk_found   = 1'b0;
    lk_idx     = '0;
    upd_found  = 1'b0;
    upd_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == lk_pc) begin
        lk_found = 1'b1;
        lk_idx   = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == upd_pc) begin
        upd_found = 1'b1;
        upd_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lk_hit   = lk_found;
    lk_taken = lk_found && ctr_q[lk_idx][CTR_W-1];
    pred_pc  = lk_taken ? target_q[lk_idx] : lk_pc;
  end

  always_comb begin
    alloc  = upd_valid && !flush && !upd_found && upd_taken;
    victim = free_found ? free_idx : ptr_q;
  end

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (alloc) begin
      valid_d[victim] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      ptr_q       <= '0;
      mispred_cnt <= '0;
      valid_cnt   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      // Misprediction accounting is independent of flush and of hit/miss.
      if (upd_valid && (upd_taken != upd_pred_taken)) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
      valid_q   <= valid_d;
      valid_cnt <= cnt_d;
      if (flush) begin
        ptr_q <= '0;
      end else if (upd_valid && upd_found) begin
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
          if (ctr_q[upd_idx] != CTR_MAX) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
          end
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (alloc) begin
        tag_q[victim]    <= upd_pc;
        target_q[victim] <= upd_target;
        ctr_q[victim]    <= CTR_WEAK;
        if (!free_found) begin
          ptr_q <= ptr_q + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - randomized and directed bench for branch_target_buffer
// Reference model keeps the table as plain arrays and applies the update rules directly.
module tb_branch_target_buffer;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 4;
  localparam int CTR_MAX = 3;
  localparam int CTR_WEAK = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [XLEN-1:0]   pred_pc;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic [XLEN-1:0]   upd_target;
  logic              upd_taken;
  logic              upd_pred_taken;
  logic              flush;
  logic [31:0]       mispred_cnt;
  logic [2:0]        valid_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_ptr;
  logic [31:0] m_mis;

  branch_target_buffer #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(2)) dut (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .pred_pc(pred_pc), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken), .flush(flush),
    .mispred_cnt(mispred_cnt), .valid_cnt(valid_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_ptr = 0;
    m_mis = '0;
  endtask

  function automatic int model_find(input logic [31:0] pc);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) n += m_valid[i];
    return n;
  endfunction

  task automatic model_update(input bit uv, input logic [31:0] pc, input logic [31:0] tgt,
                              input bit t, input bit pt, input bit fl);
    int h;
    int v;
    if (uv && t != pt) m_mis = m_mis + 1;
    if (fl) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      m_ptr = 0;
    end else if (uv) begin
      h = model_find(pc);
      if (h >= 0) begin
        if (t) begin
          m_ctr[h] = (m_ctr[h] < CTR_MAX) ? m_ctr[h] + 1 : CTR_MAX;
          m_tgt[h] = tgt;
        end else begin
          m_ctr[h] = (m_ctr[h] > 0) ? m_ctr[h] - 1 : 0;
        end
      end else if (t) begin
        v = -1;
        for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) v = i;
        if (v < 0) begin
          v = m_ptr;
          m_ptr = (m_ptr + 1) % ENTRIES;
        end
        m_valid[v] = 1; m_tag[v] = pc; m_tgt[v] = tgt; m_ctr[v] = CTR_WEAK;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    int h;
    bit eh;
    bit et;
    h  = model_find(lk_pc);
    eh = (h >= 0);
    et = eh && (m_ctr[h] >= CTR_WEAK);
    check({tag, ".hit"}, 64'(lk_hit), 64'(eh));
    check({tag, ".taken"}, 64'(lk_taken), 64'(et));
    check({tag, ".pred"}, 64'(pred_pc), et ? 64'(m_tgt[h]) : 64'(lk_pc));
    check({tag, ".vcnt"}, 64'(valid_cnt), 64'(model_count()));
    check({tag, ".mis"}, 64'(mispred_cnt), 64'(m_mis));
  endtask

  // One clock: drive, check lookup mid-cycle (old state), clock it in, advance the model.
  task automatic cycle(input string tag, input bit uv, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit t, input bit pt, input bit fl, input logic [31:0] lpc);
    upd_valid = uv; upd_pc = pc; upd_target = tgt; upd_taken = t;
    upd_pred_taken = pt; flush = fl; lk_pc = lpc;
    @(negedge clk);
    compare_model(tag);
    @(posedge clk);
    model_update(uv, pc, tgt, t, pt, fl);
    #1;
    upd_valid = 0; flush = 0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc);
    lk_pc = pc;
    #1;
    compare_model(tag);
  endtask

  initial begin
    rst = 1; upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
    upd_pred_taken = 0; flush = 0; lk_pc = 32'h100;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("rst.hit", 64'(lk_hit), 64'd0);
    check("rst.taken", 64'(lk_taken), 64'd0);
    check("rst.pred", 64'(pred_pc), 64'h100);
    check("rst.vcnt", 64'(valid_cnt), 64'd0);
    check("rst.mis", 64'(mispred_cnt), 64'd0);
    @(posedge clk); #1;

    cycle("alloc100", 1, 32'h100, 32'h200, 1, 0, 0, 32'h100);
    check("a100.hit", 64'(lk_hit), 64'd1);
    check("a100.taken", 64'(lk_taken), 64'd1);
    check("a100.pred", 64'(pred_pc), 64'h200);
    check("a100.vcnt", 64'(valid_cnt), 64'd1);
    check("a100.mis", 64'(mispred_cnt), 64'd1);

    cycle("nt1", 1, 32'h100, 32'h0, 0, 1, 0, 32'h100);
    cycle("nt2", 1, 32'h100, 32'h0, 0, 1, 0, 32'h100);
    check("nt.hit", 64'(lk_hit), 64'd1);
    check("nt.taken", 64'(lk_taken), 64'd0);
    check("nt.pred", 64'(pred_pc), 64'h100);
    for (int i = 0; i < 4; i++) cycle("sat", 1, 32'h100, 32'h200, 1, 1, 0, 32'h100);
    cycle("satdec", 1, 32'h100, 32'h0, 0, 0, 0, 32'h100);
    check("sat.taken", 64'(lk_taken), 64'd1);

    cycle("flush0", 0, 32'h0, 32'h0, 0, 0, 1, 32'h100);
    for (int i = 1; i <= 5; i++)
      cycle("fill", 1, 32'(i * 16), 32'(i * 16 + 32'h1000), 1, 1, 0, 32'h10);
    look("l10", 32'h10);
    check("evict.l10", 64'(lk_hit), 64'd0);
    look("l50", 32'h50);
    check("evict.l50", 64'(lk_hit), 64'd1);
    check("evict.vcnt", 64'(valid_cnt), 64'd4);
    cycle("a60", 1, 32'h60, 32'h1060, 1, 1, 0, 32'h20);
    look("l20", 32'h20);
    check("evict.l20", 64'(lk_hit), 64'd0);

    cycle("flush70", 1, 32'h70, 32'h1070, 1, 0, 1, 32'h30);
    check("fl.vcnt", 64'(valid_cnt), 64'd0);
    check("fl.mis", 64'(mispred_cnt), 64'(m_mis));
    look("fl70", 32'h70);
    check("fl.l70", 64'(lk_hit), 64'd0);
    look("fl30", 32'h30);
    check("fl.l30", 64'(lk_hit), 64'd0);

    cycle("a100b", 1, 32'h100, 32'h200, 1, 1, 0, 32'h100);
    cycle("retgt", 1, 32'h100, 32'h300, 1, 1, 0, 32'h100);
    check("retgt.pred", 64'(pred_pc), 64'h300);
    cycle("miss900", 1, 32'h900, 32'h999, 0, 0, 0, 32'h900);
    check("m900.hit", 64'(lk_hit), 64'd0);
    check("m900.vcnt", 64'(valid_cnt), 64'd1);

    #2 rst = 1;
    #1;
    model_reset();
    check("arst.hit", 64'(lk_hit), 64'd0);
    check("arst.taken", 64'(lk_taken), 64'd0);
    check("arst.pred", 64'(pred_pc), 64'(lk_pc));
    check("arst.vcnt", 64'(valid_cnt), 64'd0);
    check("arst.mis", 64'(mispred_cnt), 64'd0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    for (int n = 0; n < 500; n++) begin
      cycle("rnd", $urandom_range(0, 3) != 0, 32'($urandom_range(1, 8) * 16),
            32'h4000 + 32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
            32'($urandom_range(1, 8) * 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
